shift_register_stream: RTL
==========================

// Module: shift_register_stream
// PURPOSE
//  Parametrised successor to the single-shot shift register. Serialises a stream of W-bit
//  words (e.g. 24-bit GRB pixels for the LED chain) onto one output bit, with configurable
//  bit order and bit period. A one-entry holding buffer behind a valid/ready handshake
//  allows back-to-back words with no gap. Sits between the frame/pixel source and the LED line encoder.
// PARAMETERS
//  W           24  word width in bits (>=2)
//  MSB_FIRST   1   1: bit W-1 shifted first; 0: bit 0 first
//  BIT_CYCLES  1   clk cycles each bit is held on out (>=1)
//  IDLE_LEVEL  0   value driven on out when no word is shifting
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rstn        in   1   asynchronous active-low reset
//  en          in   1   shift enable; low pauses bit timing (freeze), buffer still accepts
//  in_data     in   W   word to serialise
//  in_valid    in   1   in_data valid
//  in_ready    out  1   buffer can accept; transfer when in_valid & in_ready at clk edge
//  out         out  1   serial data bit
//  bit_strobe  out  1   1-cycle pulse on first cycle each new bit is presented on out
//  busy        out  1   shifter holds a word (state SHIFT)
//  done        out  1   1-cycle pulse on final cycle of a word's last bit
// BEHAVIOUR
//  Reset (async, rstn=0): state IDLE, buffer empty, counters 0; in_ready=1, out=IDLE_LEVEL,
//   bit_strobe=0, busy=0, done=0. Reset mid-word discards shifter and buffer contents.
//  Buffer: full flag set on accepted transfer, cleared when shifter loads from it.
//   in_ready = !full (registered-flag based, no comb. path from in_valid).
//   Accept and load in same cycle: buffer takes the new word, stays full.
//  FSM IDLE: if buffer full -> load shifter, bit_cnt=0, div_cnt=0, go SHIFT (en not required to load).
//   First bit on out from the load edge: accept at edge k -> load at edge k+1 -> bit 0 visible after k+1.
//  FSM SHIFT (en=1): div_cnt counts 0..BIT_CYCLES-1; at BIT_CYCLES-1 shift one bit, bit_cnt++.
//   Last cycle of bit W-1 (bit_cnt=W-1, div_cnt=BIT_CYCLES-1): done=1; if buffer full,
//   load next word at that edge and stay SHIFT (zero gap); else go IDLE, out=IDLE_LEVEL.
//  en=0 in SHIFT: div_cnt, bit_cnt, shifter and out frozen; no strobe/done; resumes on en=1.
//  out is registered (shifter bit W-1 if MSB_FIRST else bit 0); bit_strobe asserted with load
//   and with each shift; busy=1 exactly while state SHIFT.
//  Counter widths: bit_cnt $clog2(W), div_cnt max($clog2(BIT_CYCLES),1); no wrap beyond limits.
//  Bit period: each bit exactly BIT_CYCLES enabled cycles; word = W*BIT_CYCLES enabled cycles.
// TESTING
//  1 W=24,MSB_FIRST=1,BIT_CYCLES=1, in_data=24'hE15F11 single word -> out=1,1,1,0,0,0,0,1,...,0,0,0,1
//    from cycle after load, 24 strobes, done pulse at bit 23, then out=0, busy=0, in_ready=1.
//  2 MSB_FIRST=0 same word -> out LSB first: 1,0,0,0,1,0,0,0,...; done after 24 cycles.
//  3 BIT_CYCLES=4, two words 24'hFFFFFF,24'h000000 streamed -> each bit held 4 cycles, second word
//    starts on edge after first done (no IDLE cycle), 2 done pulses 96 cycles apart, busy high throughout.
//  4 Backpressure: 3 valid words presented continuously -> in_ready low while buffer full, all words
//    serialised in order, none lost or duplicated.
//  5 en toggled low 5 cycles mid-word (bit 10) -> out frozen, no strobe; word completes 5 cycles late.
//  6 rstn low at bit 12 of a word with buffer full -> immediately out=0, busy=0, in_ready=1; after
//    release nothing shifts until a new in_valid.

Source files
------------

// File: rtl/shift_register_stream_if.sv
// Word-input handshake for shift_register_stream: W-bit data with valid/ready flow control.
interface shift_register_stream_if #(
  parameter int W = 24
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/shift_register_stream.sv
// Streaming serialiser: one-word holding buffer feeding a W-bit shifter that drives one
// output bit, each bit held BIT_CYCLES enabled cycles, back-to-back words with no gap.
module shift_register_stream #(
  parameter int   W          = 24,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter int   BIT_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  shift_register_stream_if.slave in_if,
  output logic                   out,
  output logic                   bit_strobe,
  output logic                   busy,
  output logic                   done
);

  localparam int BW = $clog2(W);
  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  buf_q, buf_d;
  logic          full_q, full_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          out_q, out_d;
  logic          strobe_q, strobe_d;

  logic          accept;
  logic          load;
  logic [W-1:0]  sh_next;

  // Bit presented on out for a given shifter image.
  function automatic logic head(input logic [W-1:0] v);
    return MSB_FIRST ? v[W-1] : v[0];
  endfunction

  // in_ready comes only from the registered full flag, never from in_valid.
  assign in_if.in_ready = ~full_q;
  assign accept         = in_if.in_valid & ~full_q;
  assign sh_next        = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    div_d    = div_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    load     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE: begin
        load = full_q;
      end
      S_SHIFT: begin
        if (en) begin
          if (div_q == DIV_LAST) begin
            div_d = '0;
            if (bit_q == BIT_LAST) begin
              done = 1'b1;
              load = full_q;
              if (!full_q) begin
                state_d = S_IDLE;
                out_d   = IDLE_LEVEL;
              end
            end else begin
              sh_d     = sh_next;
              bit_d    = bit_q + 1'b1;
              out_d    = head(sh_next);
              strobe_d = 1'b1;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A load (from IDLE or chained off the last bit) overrides the shift bookkeeping.
    if (load) begin
      state_d  = S_SHIFT;
      sh_d     = buf_q;
      bit_d    = '0;
      div_d    = '0;
      out_d    = head(buf_q);
      strobe_d = 1'b1;
    end
  end

  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    if (accept) begin
      full_d = 1'b1;
      buf_d  = in_if.in_data;
    end else if (load) begin
      full_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      // NOTE: the one-word data buffer and shifter are reset with the control state so no X can reach out.
      buf_q    <= '0;
      full_q   <= 1'b0;
      sh_q     <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      out_q    <= IDLE_LEVEL;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      out_q    <= out_d;
      strobe_q <= strobe_d;
    end
  end

  assign out        = out_q;
  assign bit_strobe = strobe_q;
  assign busy       = (state_q == S_SHIFT);

endmodule
